inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer.sv | 94 +++++++++
 tb/tb_inst_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: in-order instruction FIFO decoupling fetch from decode.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module inst_buffer #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid,
  output logic                   enq_ready,
  input  logic [XLEN-1:0]        enq_pc,
  input  logic [31:0]            enq_inst,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [XLEN-1:0]        deq_pc,
  output logic [31:0]            deq_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_count;
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_inst [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_enq;
  logic            w_deq;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;

  // Status flags and handshakes, derived from registered pointers only
  always_comb begin
    w_wr_idx  = r_wr_ptr[AW-1:0];
    w_rd_idx  = r_rd_ptr[AW-1:0];
    w_empty   = (r_wr_ptr == r_rd_ptr);
    w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    enq_ready = ~w_full;
    deq_valid = ~w_empty;
    w_enq     = enq_valid & ~w_full & ~flush;
    w_deq     = deq_ready & ~w_empty & ~flush;
  end

  // Head entry is presented only while valid; zeros otherwise
  always_comb begin
    deq_pc   = '0;
    deq_inst = '0;
    if (!w_empty) begin
      deq_pc   = r_mem_pc[w_rd_idx];
      deq_inst = r_mem_inst[w_rd_idx];
    end
  end

  assign count = r_count;

  // Pointer and occupancy state; flush clears everything and wins over traffic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_pc[w_wr_idx]   <= enq_pc;
      r_mem_inst[w_wr_idx] <= enq_inst;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed and randomized traffic against a queue-based model.
module tb_inst_buffer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [63:0] enq_pc;
  logic [31:0] enq_inst;
  logic        deq_valid;
  logic        deq_ready;
  logic [63:0] deq_pc;
  logic [31:0] deq_inst;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  ent_t exp_q[$];

  inst_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_inst  (enq_inst),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_inst  (deq_inst),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Drive one cycle of inputs starting just after an edge; return just after the next edge
  task automatic cyc(input logic ev, input logic [63:0] pc, input logic [31:0] in,
                     input logic dr, input logic fl);
    enq_valid = ev;
    enq_pc    = pc;
    enq_inst  = in;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Monitor + reference model: check outputs mid-cycle, then predict the coming edge
  always @(negedge clk) begin
    int   sz;
    ent_t head;
    if (!rst) exp_q.delete();
    sz = exp_q.size();
    chk("count", 96'(count), 96'(sz));
    chk("enq_ready", 96'(enq_ready), 96'(sz < DEPTH));
    chk("deq_valid", 96'(deq_valid), 96'(sz > 0));
    if (sz > 0) begin
      head = exp_q[0];
      chk("deq_pc", 96'(deq_pc), 96'(head.pc));
      chk("deq_inst", 96'(deq_inst), 96'(head.inst));
    end else begin
      chk("deq_pc_idle", 96'(deq_pc), 96'(0));
      chk("deq_inst_idle", 96'(deq_inst), 96'(0));
    end
    if (rst) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (deq_ready && sz > 0) void'(exp_q.pop_front());
        if (enq_valid && sz < DEPTH) exp_q.push_back('{pc: enq_pc, inst: enq_inst});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] pc;
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", 96'(count), 96'(0));
    chk("reset_enq_ready", 96'(enq_ready), 96'(1));
    rst = 1'b1;

    // Single enqueue shows up one cycle later
    cyc(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
    chk("single_valid", 96'(deq_valid), 96'(1));
    chk("single_pc", 96'(deq_pc), 96'(64'h8000_0000));
    chk("single_inst", 96'(deq_inst), 96'(32'h0000_0013));
    chk("single_count", 96'(count), 96'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("single_drained", 96'(count), 96'(0));

    // Fill to full with a fifth pending, then drain in order
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h8000_0000 + 64'(4 * i), 32'(i), 1'b0, 1'b0);
    chk("full_count", 96'(count), 96'(4));
    chk("full_enq_ready", 96'(enq_ready), 96'(0));
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 96'(deq_pc), 96'(64'h8000_0000 + 64'(4 * i)));
      cyc(1'b0, '0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 96'(deq_valid), 96'(0));

    // Full with both sides active: dequeue alone, then both fire
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'hA000_0000 + 64'(4 * i), 32'(16 + i), 1'b0, 1'b0);
    cyc(1'b1, 64'hA000_0010, 32'd20, 1'b1, 1'b0);
    chk("fulldeq_count", 96'(count), 96'(3));
    chk("fulldeq_ready", 96'(enq_ready), 96'(1));
    cyc(1'b1, 64'hA000_0010, 32'd20, 1'b1, 1'b0);
    chk("both_count", 96'(count), 96'(3));
    repeat (4) cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with a simultaneous enqueue
    cyc(1'b1, 64'hB000_0000, 32'd30, 1'b0, 1'b0);
    cyc(1'b1, 64'hB000_0004, 32'd31, 1'b0, 1'b0);
    cyc(1'b1, 64'hB000_0008, 32'd32, 1'b0, 1'b1);
    chk("flush_count", 96'(count), 96'(0));
    chk("flush_valid", 96'(deq_valid), 96'(0));
    chk("flush_pc", 96'(deq_pc), 96'(0));
    chk("flush_inst", 96'(deq_inst), 96'(0));
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_not_stored", 96'(count), 96'(0));

    // Streaming through pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 64'h9000_0000 + 64'(4 * i), 32'(100 + i), 1'b1, 1'b0);
      chk("stream_count", 96'(count), 96'(1));
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Half-cycle asynchronous reset with three stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'hC000_0000 + 64'(4 * i), 32'(200 + i), 1'b0, 1'b0);
    chk("pre_reset_count", 96'(count), 96'(3));
    enq_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_valid", 96'(deq_valid), 96'(0));
    chk("async_count", 96'(count), 96'(0));
    chk("async_pc", 96'(deq_pc), 96'(0));
    #4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 64'hD000_0000, 32'h1234_5678, 1'b0, 1'b0);
    chk("post_reset_pc", 96'(deq_pc), 96'(64'hD000_0000));
    chk("post_reset_count", 96'(count), 96'(1));
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic
    pc = 64'h4000_0000;
    for (int i = 0; i < 400; i++) begin
      logic ev, dr, fl;
      ev = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 39) == 0);
      cyc(ev, pc, $urandom, dr, fl);
      if (ev) pc = pc + 64'd4;
    end
    repeat (DEPTH + 1) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("final_empty", 96'(count), 96'(0));

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
